// File: rtl/key_matrix_ps2_if.sv
// Bus bundle for key_matrix_ps2: PS/2 key events, map-table writes, joystick inputs
// and the row-strobe / column-return lines of the emulated matrix.
interface key_matrix_ps2_if #(
  parameter int unsigned ROWS         = 8,
  parameter int unsigned COLS         = 8,
  parameter int unsigned JOY_CHANNELS = 2
);
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned MW = 2 + RW + CW;
  // With no joystick channels the vector is one bit wide and unused.
  localparam int unsigned JW = (JOY_CHANNELS == 0) ? 1 : 5 * JOY_CHANNELS;

  logic [10:0]     ps2_key_i;
  logic            map_we_i;
  logic [8:0]      map_code_i;
  logic [MW-1:0]   map_data_i;
  logic [JW-1:0]   joy_i;
  logic            all_release_i;
  logic [ROWS-1:0] sel_n_i;
  logic [COLS-1:0] keys_n_o;
  logic            ev_o;

  modport master (
    output ps2_key_i, map_we_i, map_code_i, map_data_i, joy_i, all_release_i, sel_n_i,
    input  keys_n_o, ev_o
  );

  modport slave (
    input  ps2_key_i, map_we_i, map_code_i, map_data_i, joy_i, all_release_i, sel_n_i,
    output keys_n_o, ev_o
  );
endinterface

// File: rtl/key_matrix_ps2.sv
// PS/2 scancode to keyboard-matrix emulator with joystick merge.
// Optional macro KEY_MATRIX_SEEN_EN: a released key is held until its row has been scanned once.
module key_matrix_ps2 #(
  parameter int unsigned ROWS         = 8,
  parameter int unsigned COLS         = 8,
  parameter int unsigned JOY_CHANNELS = 2
) (
  input logic             clk_i,
  input logic             reset_n_i,
  key_matrix_ps2_if.slave bus
);
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned MW = 2 + RW + CW;

  typedef logic [ROWS-1:0][COLS-1:0] mat_t;

  logic [MW-1:0]   map_mem [512];
  logic [MW-1:0]   ent_q;
  logic            tog_q;
  logic            s1_vld_q;
  logic            s1_prs_q;
  logic            ev_q;
  logic            ev_d;
  mat_t            mom_q, mom_d;
  mat_t            tgl_q, tgl_d;
  mat_t            joy_mat;
  logic [RW-1:0]   ent_row;
  logic [CW-1:0]   ent_col;
  logic            ent_ok;
  logic [COLS-1:0] keys_n_c;
`ifdef KEY_MATRIX_SEEN_EN
  mat_t            seen_q, seen_d;
  mat_t            pend_q, pend_d;
`endif

  // Map table: read-before-write, so a same-cycle write and lookup of one code returns old data
  always_ff @(posedge clk_i) begin
    if (bus.map_we_i) map_mem[bus.map_code_i] <= bus.map_data_i;
    ent_q <= map_mem[bus.ps2_key_i[8:0]];
  end

  // Event detect; the toggle copy tracks the input during reset so release causes no event
  always_ff @(posedge clk_i) begin
    tog_q <= bus.ps2_key_i[10];
    if (!reset_n_i) begin
      s1_vld_q <= 1'b0;
      s1_prs_q <= 1'b0;
    end else begin
      s1_vld_q <= bus.ps2_key_i[10] ^ tog_q;
      s1_prs_q <= bus.ps2_key_i[9];
    end
  end

  assign ent_row = ent_q[CW +: RW];
  assign ent_col = ent_q[0 +: CW];
  assign ent_ok  = ent_q[MW-1] && (32'(ent_row) < ROWS) && (32'(ent_col) < COLS);

  // Joystick channel j lands on column j: fire, left, right, down, up on rows 0..4
  always_comb begin
    joy_mat = '0;
    for (int j = 0; j < JOY_CHANNELS; j++) begin
      joy_mat[0][j] = bus.joy_i[5*j+4];
      joy_mat[1][j] = bus.joy_i[5*j+1];
      joy_mat[2][j] = bus.joy_i[5*j+0];
      joy_mat[3][j] = bus.joy_i[5*j+2];
      joy_mat[4][j] = bus.joy_i[5*j+3];
    end
  end

  always_comb begin
    keys_n_c = '1;
    for (int r = 0; r < ROWS; r++) begin
      if (!bus.sel_n_i[r]) keys_n_c = keys_n_c & ~(mom_q[r] | tgl_q[r] | joy_mat[r]);
    end
  end

  assign bus.keys_n_o = keys_n_c;
  assign bus.ev_o     = ev_q;

  // Matrix next state: scan bookkeeping first, then all-release or the looked-up event
  always_comb begin
    mom_d = mom_q;
    tgl_d = tgl_q;
    ev_d  = 1'b0;
`ifdef KEY_MATRIX_SEEN_EN
    seen_d = seen_q;
    pend_d = pend_q;
    for (int r = 0; r < ROWS; r++) begin
      if (!bus.sel_n_i[r]) begin
        mom_d[r]  = mom_q[r] & ~pend_q[r];
        seen_d[r] = (seen_q[r] | mom_q[r]) & ~pend_q[r];
        pend_d[r] = '0;
      end
    end
`endif
    if (bus.all_release_i) begin
      mom_d = '0;
`ifdef KEY_MATRIX_SEEN_EN
      seen_d = '0;
      pend_d = '0;
`endif
    end else if (s1_vld_q && ent_ok) begin
      ev_d = 1'b1;
      if (ent_q[MW-2]) begin
        if (s1_prs_q) tgl_d[ent_row][ent_col] = ~tgl_q[ent_row][ent_col];
      end else if (s1_prs_q) begin
        mom_d[ent_row][ent_col] = 1'b1;
`ifdef KEY_MATRIX_SEEN_EN
        pend_d[ent_row][ent_col] = 1'b0;
`endif
      end else begin
`ifdef KEY_MATRIX_SEEN_EN
        if (seen_d[ent_row][ent_col]) begin
          mom_d[ent_row][ent_col]  = 1'b0;
          seen_d[ent_row][ent_col] = 1'b0;
        end else if (mom_d[ent_row][ent_col]) begin
          pend_d[ent_row][ent_col] = 1'b1;
        end
`else
        mom_d[ent_row][ent_col] = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      mom_q  <= '0;
      tgl_q  <= '0;
      ev_q   <= 1'b0;
`ifdef KEY_MATRIX_SEEN_EN
      seen_q <= '0;
      pend_q <= '0;
`endif
    end else begin
      mom_q  <= mom_d;
      tgl_q  <= tgl_d;
      ev_q   <= ev_d;
`ifdef KEY_MATRIX_SEEN_EN
      seen_q <= seen_d;
      pend_q <= pend_d;
`endif
    end
  end
endmodule
